// File: rtl/d_ex_issue_reg_if.sv
// Decode/hazard-side bundle feeding the D/EX issue register, plus the
// registered EX-side results it returns.
interface d_ex_issue_reg_if #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5
);
  // Decode slot
  logic                 D_valid;
  logic [XLEN-1:0]      D_pc;
  logic [ADDR_SIZE-1:0] D_rd;
  logic [ADDR_SIZE-1:0] D_ra;
  logic [ADDR_SIZE-1:0] D_rb;
  logic [XLEN-1:0]      D_ra_val;
  logic [XLEN-1:0]      D_rb_val;
  logic                 D_we;
  logic                 D_ld;
  logic [3:0]           D_alu_op;
  logic [XLEN-1:0]      D_imm;

  // Hazard unit decisions and forwarded stage values
  logic                 stall_D;
  logic [1:0]           EX_D_bp;
  logic [1:0]           MEM_D_bp;
  logic [1:0]           WB_D_bp;
  logic [XLEN-1:0]      EX_alu_out;
  logic [XLEN-1:0]      Mem_data_mem;
  logic [XLEN-1:0]      WB_data_mem;
  logic                 flush;

  // EX slot and pipeline control
  logic                 F_D_hold;
  logic                 EX_valid;
  logic [XLEN-1:0]      EX_pc;
  logic [ADDR_SIZE-1:0] EX_rd;
  logic                 EX_we;
  logic                 EX_ld;
  logic [3:0]           EX_alu_op;
  logic [XLEN-1:0]      EX_a;
  logic [XLEN-1:0]      EX_b;
  logic [XLEN-1:0]      EX_imm;
  logic [15:0]          stall_cnt;

  modport master (
    output D_valid, D_pc, D_rd, D_ra, D_rb, D_ra_val, D_rb_val,
           D_we, D_ld, D_alu_op, D_imm,
           stall_D, EX_D_bp, MEM_D_bp, WB_D_bp,
           EX_alu_out, Mem_data_mem, WB_data_mem, flush,
    input  F_D_hold, EX_valid, EX_pc, EX_rd, EX_we, EX_ld, EX_alu_op,
           EX_a, EX_b, EX_imm, stall_cnt
  );

  modport slave (
    input  D_valid, D_pc, D_rd, D_ra, D_rb, D_ra_val, D_rb_val,
           D_we, D_ld, D_alu_op, D_imm,
           stall_D, EX_D_bp, MEM_D_bp, WB_D_bp,
           EX_alu_out, Mem_data_mem, WB_data_mem, flush,
    output F_D_hold, EX_valid, EX_pc, EX_rd, EX_we, EX_ld, EX_alu_op,
           EX_a, EX_b, EX_imm, stall_cnt
  );
endinterface

// File: rtl/d_ex_issue_reg.sv
// Decode-to-execute issue register: resolves forwarded operands, then either
// launches the decoded instruction into EX or inserts a bubble.
module d_ex_issue_reg #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5
) (
  input logic              clk,
  input logic              rst,
  d_ex_issue_reg_if.slave  bus
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            issue;

  // Bypass priority EX > MEM > WB > register file; x0 always reads as zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    op_a = bus.D_ra_val;
    if (bus.EX_D_bp[1])       op_a = bus.EX_alu_out;
    else if (bus.MEM_D_bp[1]) op_a = bus.Mem_data_mem;
    else if (bus.WB_D_bp[1])  op_a = bus.WB_data_mem;
    if (bus.D_ra == '0)       op_a = '0;

    op_b = bus.D_rb_val;
    if (bus.EX_D_bp[0])       op_b = bus.EX_alu_out;
    else if (bus.MEM_D_bp[0]) op_b = bus.Mem_data_mem;
    else if (bus.WB_D_bp[0])  op_b = bus.WB_data_mem;
    if (bus.D_rb == '0)       op_b = '0;
  end

  // Flush dominates stall: the stalled instruction is dead, fetch must redirect.
  assign bus.F_D_hold = bus.stall_D & ~bus.flush & ~rst;
  assign issue        = bus.D_valid & ~bus.stall_D & ~bus.flush;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      bus.EX_valid  <= 1'b0;
      bus.EX_pc     <= '0;
      bus.EX_rd     <= '0;
      bus.EX_we     <= 1'b0;
      bus.EX_ld     <= 1'b0;
      bus.EX_alu_op <= '0;
      bus.EX_a      <= '0;
      bus.EX_b      <= '0;
      bus.EX_imm    <= '0;
      bus.stall_cnt <= '0;
    end else begin
      if (bus.F_D_hold && bus.stall_cnt != 16'hFFFF)
        bus.stall_cnt <= bus.stall_cnt + 16'd1;

      if (issue) begin
        bus.EX_valid  <= 1'b1;
        bus.EX_pc     <= bus.D_pc;
        bus.EX_rd     <= bus.D_rd;
        bus.EX_we     <= bus.D_we & bus.D_valid;
        bus.EX_ld     <= bus.D_ld & bus.D_valid;
        bus.EX_alu_op <= bus.D_alu_op;
        bus.EX_a      <= op_a;
        bus.EX_b      <= op_b;
        bus.EX_imm    <= bus.D_imm;
      end else begin
        // Bubble: fully zeroed so it can never match a hazard downstream.
        bus.EX_valid  <= 1'b0;
        bus.EX_pc     <= '0;
        bus.EX_rd     <= '0;
        bus.EX_we     <= 1'b0;
        bus.EX_ld     <= 1'b0;
        bus.EX_alu_op <= '0;
        bus.EX_a      <= '0;
        bus.EX_b      <= '0;
        bus.EX_imm    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_d_ex_issue_reg.sv
// Directed self-checking bench for d_ex_issue_reg with hand-computed expectations.
module tb_d_ex_issue_reg;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  d_ex_issue_reg_if #(.XLEN(32), .ADDR_SIZE(5)) bus ();

  d_ex_issue_reg #(.XLEN(32), .ADDR_SIZE(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bypass();
    bus.EX_D_bp  = 2'b00;
    bus.MEM_D_bp = 2'b00;
    bus.WB_D_bp  = 2'b00;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset with random decode inputs and a stall request held during reset
    rst              = 1'b1;
    bus.D_valid      = 1'b1;
    bus.D_pc         = $urandom;
    bus.D_rd         = 5'($urandom);
    bus.D_ra         = 5'($urandom);
    bus.D_rb         = 5'($urandom);
    bus.D_ra_val     = $urandom;
    bus.D_rb_val     = $urandom;
    bus.D_we         = 1'b1;
    bus.D_ld         = 1'b1;
    bus.D_alu_op     = 4'($urandom);
    bus.D_imm        = $urandom;
    bus.stall_D      = 1'b1;
    bus.flush        = 1'b0;
    bus.EX_alu_out   = $urandom;
    bus.Mem_data_mem = $urandom;
    bus.WB_data_mem  = $urandom;
    bus.EX_D_bp      = 2'b11;
    bus.MEM_D_bp     = 2'b11;
    bus.WB_D_bp      = 2'b11;
    tick();
    tick();
    check("rst_valid",  bus.EX_valid,  0);
    check("rst_pc",     bus.EX_pc,     0);
    check("rst_we",     bus.EX_we,     0);
    check("rst_ld",     bus.EX_ld,     0);
    check("rst_a",      bus.EX_a,      0);
    check("rst_b",      bus.EX_b,      0);
    check("rst_imm",    bus.EX_imm,    0);
    check("rst_hold",   bus.F_D_hold,  0);
    check("rst_cnt",    bus.stall_cnt, 0);

    // Plain issue from the register file
    rst          = 1'b0;
    bus.stall_D  = 1'b0;
    clear_bypass();
    bus.D_valid  = 1'b1;
    bus.D_pc     = 32'h100;
    bus.D_rd     = 5'd5;
    bus.D_ra     = 5'd3;
    bus.D_ra_val = 32'h11;
    bus.D_rb     = 5'd4;
    bus.D_rb_val = 32'h22;
    bus.D_we     = 1'b1;
    bus.D_ld     = 1'b0;
    bus.D_alu_op = 4'h3;
    bus.D_imm    = 32'h7;
    #1;
    check("plain_hold", bus.F_D_hold, 0);
    tick();
    check("plain_valid", bus.EX_valid,  1);
    check("plain_a",     bus.EX_a,      32'h11);
    check("plain_b",     bus.EX_b,      32'h22);
    check("plain_we",    bus.EX_we,     1);
    check("plain_ld",    bus.EX_ld,     0);
    check("plain_pc",    bus.EX_pc,     32'h100);
    check("plain_rd",    bus.EX_rd,     5);
    check("plain_op",    bus.EX_alu_op, 3);
    check("plain_imm",   bus.EX_imm,    32'h7);

    // Forward priority: A sees EX and MEM, B sees MEM and WB
    bus.EX_alu_out   = 32'hAA;
    bus.Mem_data_mem = 32'hBB;
    bus.WB_data_mem  = 32'hCC;
    bus.EX_D_bp      = 2'b10;
    bus.MEM_D_bp     = 2'b11;
    bus.WB_D_bp      = 2'b01;
    tick();
    check("fwd_a_ex",  bus.EX_a, 32'hAA);
    check("fwd_b_mem", bus.EX_b, 32'hBB);

    // WB only on A, nothing on B
    clear_bypass();
    bus.WB_D_bp = 2'b10;
    tick();
    check("fwd_a_wb", bus.EX_a, 32'hCC);
    check("fwd_b_rf", bus.EX_b, 32'h22);

    // x0 on A beats EX bypass; B takes WB value
    clear_bypass();
    bus.D_ra    = 5'd0;
    bus.D_rb    = 5'd7;
    bus.EX_D_bp = 2'b10;
    bus.WB_D_bp = 2'b01;
    tick();
    check("x0_a",    bus.EX_a, 0);
    check("fwd_b_wb", bus.EX_b, 32'hCC);

    // x0 on B with every bypass bit set
    bus.D_ra     = 5'd3;
    bus.D_rb     = 5'd0;
    bus.EX_D_bp  = 2'b11;
    bus.MEM_D_bp = 2'b11;
    bus.WB_D_bp  = 2'b11;
    tick();
    check("x0_b",    bus.EX_b, 0);
    check("all_a_ex", bus.EX_a, 32'hAA);

    // Load-use stall for one cycle, then MEM forward resolves A
    clear_bypass();
    bus.D_ra     = 5'd6;
    bus.D_ra_val = 32'h99;
    bus.D_rb     = 5'd4;
    bus.D_ld     = 1'b1;
    bus.stall_D  = 1'b1;
    #1;
    check("stall_hold", bus.F_D_hold, 1);
    tick();
    check("stall_bub_valid", bus.EX_valid, 0);
    check("stall_bub_we",    bus.EX_we,    0);
    check("stall_bub_a",     bus.EX_a,     0);
    check("stall_cnt1",      bus.stall_cnt, 1);
    bus.stall_D      = 1'b0;
    bus.MEM_D_bp     = 2'b10;
    bus.Mem_data_mem = 32'h55;
    #1;
    check("unstall_hold", bus.F_D_hold, 0);
    tick();
    check("ld_valid", bus.EX_valid,  1);
    check("ld_a",     bus.EX_a,      32'h55);
    check("ld_ld",    bus.EX_ld,     1);
    check("ld_cnt",   bus.stall_cnt, 1);

    // Flush and stall together: no hold, bubble, count unchanged
    clear_bypass();
    bus.flush   = 1'b1;
    bus.stall_D = 1'b1;
    #1;
    check("flush_hold", bus.F_D_hold, 0);
    tick();
    check("flush_valid", bus.EX_valid,  0);
    check("flush_we",    bus.EX_we,     0);
    check("flush_cnt",   bus.stall_cnt, 1);

    // Invalid decode slot with write and load requested
    bus.flush   = 1'b0;
    bus.stall_D = 1'b0;
    bus.D_valid = 1'b0;
    bus.D_we    = 1'b1;
    bus.D_ld    = 1'b1;
    tick();
    check("inv_we",    bus.EX_we,    0);
    check("inv_ld",    bus.EX_ld,    0);
    check("inv_valid", bus.EX_valid, 0);
    check("inv_pc",    bus.EX_pc,    0);

    // Saturation: count starts at 1, 65533 stalls reach 0xFFFE
    bus.D_valid = 1'b1;
    bus.stall_D = 1'b1;
    for (int i = 0; i < 65533; i++) tick();
    check("cnt_fffe", bus.stall_cnt, 16'hFFFE);
    for (int i = 0; i < 7; i++) tick();
    check("cnt_sat",   bus.stall_cnt, 16'hFFFF);
    check("sat_valid", bus.EX_valid,  0);

    // Reset clears the counter
    rst = 1'b1;
    tick();
    check("rst2_cnt",  bus.stall_cnt, 0);
    check("rst2_hold", bus.F_D_hold,  0);
    rst         = 1'b0;
    bus.stall_D = 1'b0;
    tick();
    check("post_rst_valid", bus.EX_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d_ex_issue_reg.md
# d_ex_issue_reg

Decode-to-execute issue register. It consumes the hazard unit's stall and bypass decisions and resolves each source operand from the register file or a forwarded stage value. It then either launches the decoded instruction into EX or inserts a bubble, and tells fetch/decode to hold while a load-use stall is active. It sits between the decode stage and the ALU; all EX-side operand values come from this block.

## Interface
Parameters:
- XLEN, 32, datapath width
- ADDR_SIZE, 5, register address width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- D_valid  input  1  decode slot holds a real instruction
- D_pc  input  XLEN  decode PC
- D_rd  input  ADDR_SIZE  destination register
- D_ra  input  ADDR_SIZE  source register A
- D_rb  input  ADDR_SIZE  source register B
- D_ra_val  input  XLEN  register-file read of ra
- D_rb_val  input  XLEN  register-file read of rb
- D_we  input  1  instruction writes rd
- D_ld  input  1  instruction is a load
- D_alu_op  input  4  ALU operation code
- D_imm  input  XLEN  decoded immediate
- stall_D  input  1  load-use stall request from hazard unit
- EX_D_bp  input  2  forward from EX; bit 1 = ra, bit 0 = rb
- MEM_D_bp  input  2  forward from MEM; same bit mapping
- WB_D_bp  input  2  forward from WB; same bit mapping
- EX_alu_out  input  XLEN  EX-stage result
- Mem_data_mem  input  XLEN  MEM-stage result
- WB_data_mem  input  XLEN  WB-stage result
- flush  input  1  branch/jump redirect kills the decode slot
- F_D_hold  output  1  hold fetch and the F/D register
- EX_valid  output  1  EX slot valid
- EX_pc  output  XLEN  registered PC
- EX_rd  output  ADDR_SIZE  registered destination
- EX_we  output  1  registered write enable
- EX_ld  output  1  registered load flag
- EX_alu_op  output  4  registered ALU op
- EX_a  output  XLEN  resolved operand A
- EX_b  output  XLEN  resolved operand B
- EX_imm  output  XLEN  registered immediate
- stall_cnt  output  16  saturating count of stall cycles

## Operation
- Operand resolution, combinational and per source, with priority EX > MEM > WB > register file:
  - A: EX_D_bp[1] ? EX_alu_out : MEM_D_bp[1] ? Mem_data_mem : WB_D_bp[1] ? WB_data_mem : D_ra_val.
  - B: the same chain on bit 0, defaulting to D_rb_val.
- x0 rule: if D_ra == 0, A = 0 regardless of bypass bits or the register-file value. The same applies to B with D_rb.
- Next-state selection on each rising edge, evaluated in priority order:
  1. rst: all EX_* outputs = 0; stall_cnt = 0.
  2. flush: bubble.
  3. stall_D: bubble.
  4. !D_valid: bubble.
  5. Otherwise: load the D_* fields and the resolved A/B into EX_*, and set EX_valid = 1.
- Bubble: EX_valid, EX_we and EX_ld = 0; EX_rd, EX_pc, EX_alu_op, EX_a, EX_b and EX_imm = 0. A bubble never writes a register and never forms a hazard match downstream.
- F_D_hold = stall_D & ~flush & ~rst, combinational. Flush dominates stall: the stalled instruction is being killed, so fetch must take the redirect.
- stall_cnt increments on every cycle in which F_D_hold = 1 is sampled. It saturates at 0xFFFF and is cleared only by rst.
- Write-enable gating: EX_we = D_we & D_valid on a load cycle. EX_ld is gated the same way.

## Timing
- Latency: decode fields and resolved operands appear on EX_* one cycle after the edge that samples them.
- Forwarded values are sampled in the same cycle the bypass bits are asserted. No internal storage of forwarded data is required.
- Stall cycle: the decode inputs are held upstream and re-presented on the following cycle. Operand resolution repeats with the new bypass bits.
- Stall of N cycles: EX receives N bubbles, then the instruction with its operands resolved in the first non-stalled cycle.
- Reset held mid-stall: outputs remain at reset values; F_D_hold = 0; stall_cnt does not count.
- After rst deasserts, the first edge with D_valid = 1 and no stall or flush produces EX_valid = 1.
- Simultaneous flush and stall_D: bubble, F_D_hold = 0, stall_cnt unchanged.
- Multiple bypass bits set for one source: the highest-priority stage wins, even when the stage values differ.

## Test plan
- Reset: rst = 1 for 2 cycles with random D_* inputs.
  - Required: all EX_* = 0, F_D_hold = 0, stall_cnt = 0.
- Plain issue: D_ra = 3, D_ra_val = 0x11; D_rb = 4, D_rb_val = 0x22; D_we = 1, no bypass bits.
  - Required: next cycle EX_a = 0x11, EX_b = 0x22, EX_valid = 1, EX_we = 1.
- Forward priority:
  - A with EX_D_bp = 2'b10, MEM_D_bp = 2'b10, EX_alu_out = 0xAA, Mem_data_mem = 0xBB: EX_a = 0xAA.
  - B with MEM_D_bp = 2'b01, WB_D_bp = 2'b01, Mem_data_mem = 0xBB, WB_data_mem = 0xCC: EX_b = 0xBB.
  - x0 case, D_ra = 0 with EX_D_bp[1] = 1: EX_a = 0.
- Load-use stall: stall_D = 1 for 1 cycle, then 0 with MEM_D_bp[1] = 1 and Mem_data_mem = 0x55.
  - Required: F_D_hold = 1 during the stall, then one bubble (EX_valid = 0, EX_we = 0).
  - Required: then the instruction issues with EX_a = 0x55; stall_cnt = 1.
- Flush versus stall: flush = 1 and stall_D = 1 in the same cycle.
  - Required: F_D_hold = 0, a bubble is issued, stall_cnt is unchanged.
  - Separately, D_valid = 0 with D_we = 1 must give EX_we = 0.
- Counter saturation: hold stall_D = 1 for 65540 cycles.
  - Required: stall_cnt = 0xFFFF, with no wrap to 0.
